pio_ep_reg_bank: RTL and testbench
==================================

PIO_EP_REG_BANK -- requirements
Module: pio_ep_reg_bank

Interface
REQ-001 SHALL have parameter TCQ, default 1, clock-to-q delay applied to all register assignments.
REQ-002 SHALL have parameter ID_RESET, default 32'h01234567, reset value of the ID register.
REQ-003 SHALL have parameter GPIO_W, default 8 (range 1..32), width of gpio_out.
REQ-004 SHALL have parameter DIPSW_W, default 4 (range 1..32), width of dipsw.
REQ-005 SHALL have parameter NUM_SCRATCH, default 4 (range 1..8), number of scratch registers.
REQ-006 SHALL have parameter WR_FIFO_AW, default 2, write-FIFO depth = 2**WR_FIFO_AW.
REQ-007 SHALL have parameter DEB_CYCLES, default 16, dipsw debounce stable-cycle count.
REQ-008 SHALL have these ports, one per line:
- clk  in  1  single clock for all logic
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- rd_addr  in  14  read word address; [13:12] BAR select, [5:0] register offset
- rd_be  in  4  read byte enable (accepted, ignored)
- rd_data  out  32  read data
- wr_addr  in  14  write word address, same layout as rd_addr
- wr_be  in  8  write byte enables; only [3:0] used
- wr_data  in  32  write data
- wr_en  in  1  write strobe, one write per asserted cycle
- wr_busy  out  1  write FIFO full
- dipsw  in  DIPSW_W  asynchronous switch inputs
- gpio_out  out  GPIO_W  general-purpose outputs

Function
REQ-009 SHALL map host byte k to bus bits [31-8k:24-8k]; register R SHALL appear on rd_data as {R[7:0],R[15:8],R[23:16],R[31:24]}, and wr_be[k] SHALL gate R byte k.
REQ-010 SHALL decode BAR0 only (addr[13:12]==2'b01); any other BAR select SHALL read 0 and ignore writes.
REQ-011 SHALL implement register offsets: 0x00 ID (RW); 0x01 GPIO (RW, GPIO_W LSBs, upper bits read 0); 0x02 DIPSW (RO, debounced); 0x03 STATUS (bits[7:0] FIFO level RO, bit 31 overflow sticky W1C); 0x04 TIMER_LO; 0x05 TIMER_HI; 0x08..0x08+NUM_SCRATCH-1 SCRATCH (RW); all other offsets read 0, writes ignored.
REQ-012 SHALL register rd_data: value for rd_addr sampled at edge N appears after edge N and holds until next edge; reads SHALL return committed state only.
REQ-013 SHALL push {wr_addr, wr_be[3:0], wr_data} into the write FIFO on every cycle wr_en=1 and FIFO not full.
REQ-014 SHALL pop and commit one FIFO entry per cycle when non-empty; an entry pushed at edge N commits at edge N+1 at the earliest, in push order.
REQ-015 SHALL drive wr_busy=1 exactly when the FIFO is full; wr_en while full SHALL drop the write and set the overflow bit even if a pop occurs the same cycle.
REQ-016 SHALL give overflow set priority over a same-cycle W1C clear.
REQ-017 SHALL pass dipsw through a 2-flop synchronizer, then update the DIPSW register only after the synchronized value is stable for DEB_CYCLES consecutive cycles; any change SHALL restart the count.
REQ-018 SHALL drive gpio_out directly from the GPIO register.

Reset
REQ-019 SHALL, on sys_rst_n=0, asynchronously set: ID=ID_RESET, GPIO=0, gpio_out=0, SCRATCH=0, DIPSW register=0, debounce count=0, FIFO empty, overflow=0, rd_data=0, wr_busy=0, timer and snapshot=0.
REQ-020 SHALL discard all FIFO entries on reset, including uncommitted writes.

Configuration
REQ-021 SHALL compile a 64-bit free-running timer only when PIO_EP_TIMER_EN is defined: counter increments every cycle and wraps at 2**64-1 to 0; reading TIMER_LO returns bits[31:0] and latches bits[63:32] into a snapshot in the same cycle; TIMER_HI returns the snapshot; writes are ignored.
REQ-022 SHALL, without PIO_EP_TIMER_EN, contain no timer logic; TIMER_LO and TIMER_HI read 0.

Structure
REQ-023 SHALL place register offsets, the BAR0 select constant and the STATUS bit positions in shared package pio_ep_pkg.
REQ-024 SHALL implement the write FIFO as sub-module pio_wr_fifo (parameter AW; push/pop/full/empty/level).

Verification
REQ-025 Reset, then read 0x00 -> rd_data=32'h67452301 one cycle later.
REQ-026 Write 0x01 data 32'hA5000000, wr_be=4'b0001 -> gpio_out=8'hA5 two edges after wr_en; read 0x01 -> 32'hA5000000.
REQ-027 Five back-to-back writes to 0x08 with depth 4 and commits forced to lag -> wr_busy=1 when level=4, 5th write dropped, STATUS bit 31=1; W1C write of 32'h00000080 clears it.
REQ-028 dipsw 4'h5 toggled for 10 cycles then held -> DIPSW reads 0 until 16 stable cycles elapse, then 32'h05000000.
REQ-029 With PIO_EP_TIMER_EN, force counter to 64'h00000000_FFFFFFFF, read TIMER_LO then TIMER_HI -> HI equals value latched at LO read, not the post-carry value; without the macro both read 0.
REQ-030 Assert sys_rst_n=0 with 3 FIFO entries pending -> no pending write commits; ID reads ID_RESET after release.

Source files
------------

// File: rtl/pio_ep_pkg.sv
// Shared register map, STATUS field positions and byte-lane helpers for the PIO endpoint register bank.
package pio_ep_pkg;

    localparam logic [1:0] BAR0_SEL     = 2'b01;

    localparam logic [5:0] OFF_ID       = 6'h00;
    localparam logic [5:0] OFF_GPIO     = 6'h01;
    localparam logic [5:0] OFF_DIPSW    = 6'h02;
    localparam logic [5:0] OFF_STATUS   = 6'h03;
    localparam logic [5:0] OFF_TIMER_LO = 6'h04;
    localparam logic [5:0] OFF_TIMER_HI = 6'h05;
    localparam logic [5:0] OFF_SCRATCH  = 6'h08;

    localparam int STAT_LVL_LSB = 0;
    localparam int STAT_LVL_W   = 8;
    localparam int STAT_OVF_BIT = 31;

    typedef struct packed {
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_entry_t;

    // Host byte k travels on bus bits [31-8k:24-8k]; this swaps between bus and register order.
    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pio_wr_fifo.sv
// Write-posting FIFO: 2**AW entries, show-ahead head, extra pointer bit separates full from empty.
module pio_wr_fifo #(
    parameter int AW = 2,
    parameter int DW = 50
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);
    import pio_ep_pkg::*;

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage is not reset; reset only clears the pointers, which discards every entry.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/pio_ep_reg_bank.sv
// PIO endpoint register bank: posted writes through a FIFO, registered reads, debounced DIP switches.
// Optional 64-bit free-running timer with hi-word snapshot is built only when PIO_EP_TIMER_EN is defined.
module pio_ep_reg_bank #(
    parameter int          TCQ         = 1,
    parameter logic [31:0] ID_RESET    = 32'h01234567,
    parameter int          GPIO_W      = 8,
    parameter int          DIPSW_W     = 4,
    parameter int          NUM_SCRATCH = 4,
    parameter int          WR_FIFO_AW  = 2,
    parameter int          DEB_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic [13:0]        rd_addr,
    input  logic [3:0]         rd_be,
    output logic [31:0]        rd_data,
    input  logic [13:0]        wr_addr,
    input  logic [7:0]         wr_be,
    input  logic [31:0]        wr_data,
    input  logic               wr_en,
    output logic               wr_busy,
    input  logic [DIPSW_W-1:0] dipsw,
    output logic [GPIO_W-1:0]  gpio_out
);
    import pio_ep_pkg::*;

    // TCQ is retained for drop-in compatibility; this description models no clock-to-q delay.
    localparam bit             TCQ_OK   = (TCQ >= 0);
    localparam int             DEB_CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_CW-1:0] DEB_LOAD = DEB_CW'(DEB_CYCLES);
    localparam logic [DEB_CW-1:0] DEB_ONE  = DEB_CW'(1);

    wr_entry_t           w_wr_entry;
    wr_entry_t           w_head;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_ovf_set;
    logic [WR_FIFO_AW:0] w_level;

    logic                w_c_bar0;
    logic [5:0]          w_c_off;
    logic [3:0]          w_c_be;
    logic [31:0]         w_c_data;
    logic                w_commit;
    logic [31:0]         w_gpio_ext;
    logic [31:0]         w_gpio_new;
    logic [31:0]         w_dip_ext;
    logic [31:0]         w_status;

    logic                w_rd_bar0;
    logic [5:0]          w_rd_off;
    logic [31:0]         w_rd_reg;

    logic [31:0]         r_id;
    logic [GPIO_W-1:0]   r_gpio;
    logic [31:0]         r_scratch [NUM_SCRATCH];
    logic                r_ovf;
    logic [31:0]         r_rd_data;

    logic [DIPSW_W-1:0]  r_dip_s1;
    logic [DIPSW_W-1:0]  r_dip_s2;
    logic [DIPSW_W-1:0]  r_dip_last;
    logic [DIPSW_W-1:0]  r_dipsw;
    logic [DEB_CW-1:0]   r_deb_cnt;

    logic                w_unused;

    assign w_wr_entry = '{addr: wr_addr, be: wr_be[3:0], data: wr_data};
    assign w_push     = wr_en & ~w_full;
    assign w_ovf_set  = wr_en & w_full;
    assign w_pop      = ~w_empty;
    assign wr_busy    = w_full;

    pio_wr_fifo #(
        .AW (WR_FIFO_AW),
        .DW ($bits(wr_entry_t))
    ) u_wr_fifo (
        .i_clk   (clk),
        .i_rst_n (sys_rst_n),
        .i_push  (w_push),
        .i_din   (w_wr_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_c_bar0 = (w_head.addr[13:12] == BAR0_SEL);
    assign w_c_off  = w_head.addr[5:0];
    assign w_c_be   = w_head.be;
    assign w_c_data = bswap32(w_head.data);
    assign w_commit = w_pop & w_c_bar0;

    always_comb begin
        w_gpio_ext = '0;
        w_gpio_ext[GPIO_W-1:0] = r_gpio;
        w_gpio_new = merge_be(w_gpio_ext, w_c_data, w_c_be);
        w_dip_ext  = '0;
        w_dip_ext[DIPSW_W-1:0] = r_dipsw;
        w_status   = '0;
        w_status[STAT_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(w_level);
        w_status[STAT_OVF_BIT] = r_ovf;
    end

    // Commit path: one FIFO entry per cycle; a fresh overflow beats a same-cycle W1C.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_id   <= ID_RESET;
            r_gpio <= '0;
            r_ovf  <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= '0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_commit && w_c_off == OFF_STATUS &&
                         w_c_be[STAT_OVF_BIT/8] && w_c_data[STAT_OVF_BIT]) begin
                r_ovf <= 1'b0;
            end
            if (w_commit) begin
                case (w_c_off)
                    OFF_ID:   r_id   <= merge_be(r_id, w_c_data, w_c_be);
                    OFF_GPIO: r_gpio <= w_gpio_new[GPIO_W-1:0];
                    default: begin
                        for (int i = 0; i < NUM_SCRATCH; i++) begin
                            if (w_c_off == OFF_SCRATCH + 6'(i))
                                r_scratch[i] <= merge_be(r_scratch[i], w_c_data, w_c_be);
                        end
                    end
                endcase
            end
        end
    end

    // Debounce: any change of the synchronized value reloads the down-counter.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dip_s1   <= '0;
            r_dip_s2   <= '0;
            r_dip_last <= '0;
            r_deb_cnt  <= '0;
            r_dipsw    <= '0;
        end else begin
            r_dip_s1 <= dipsw;
            r_dip_s2 <= r_dip_s1;
            if (r_dip_s2 != r_dip_last) begin
                r_dip_last <= r_dip_s2;
                r_deb_cnt  <= DEB_LOAD;
            end else if (r_deb_cnt != '0) begin
                r_deb_cnt <= r_deb_cnt - DEB_ONE;
                if (r_deb_cnt == DEB_ONE) r_dipsw <= r_dip_last;
            end
        end
    end

    assign w_rd_bar0 = (rd_addr[13:12] == BAR0_SEL);
    assign w_rd_off  = rd_addr[5:0];

`ifdef PIO_EP_TIMER_EN
    logic [63:0] r_timer;
    logic [31:0] r_tsnap;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_timer <= '0;
            r_tsnap <= '0;
        end else begin
            r_timer <= r_timer + 64'd1;
            if (w_rd_bar0 && w_rd_off == OFF_TIMER_LO) r_tsnap <= r_timer[63:32];
        end
    end
`endif

    always_comb begin
        w_rd_reg = '0;
        if (w_rd_bar0) begin
            case (w_rd_off)
                OFF_ID:       w_rd_reg = r_id;
                OFF_GPIO:     w_rd_reg = w_gpio_ext;
                OFF_DIPSW:    w_rd_reg = w_dip_ext;
                OFF_STATUS:   w_rd_reg = w_status;
`ifdef PIO_EP_TIMER_EN
                OFF_TIMER_LO: w_rd_reg = r_timer[31:0];
                OFF_TIMER_HI: w_rd_reg = r_tsnap;
`else
                OFF_TIMER_LO, OFF_TIMER_HI: w_rd_reg = '0;
`endif
                default: begin
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        if (w_rd_off == OFF_SCRATCH + 6'(i)) w_rd_reg = r_scratch[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_rd_data <= '0;
        else            r_rd_data <= bswap32(w_rd_reg);
    end

    assign rd_data  = r_rd_data;
    assign gpio_out = r_gpio;

    assign w_unused = ^{rd_be, wr_be[7:4], rd_addr[11:6], w_head.addr[11:6], TCQ_OK};

endmodule

// File: tb/tb_pio_ep_reg_bank.sv
// Self-checking bench for pio_ep_reg_bank: vector table plus multi-cycle sequences, reads scored via a queue.
`timescale 1ns/1ps
module tb_pio_ep_reg_bank;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic [13:0] rd_addr;
    logic [3:0]  rd_be;
    logic [31:0] rd_data;
    logic [13:0] wr_addr;
    logic [7:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_busy;
    logic [3:0]  dipsw;
    logic [7:0]  gpio_out;

    always #5 clk = ~clk;

    pio_ep_reg_bank dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .rd_addr   (rd_addr),
        .rd_be     (rd_be),
        .rd_data   (rd_data),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .wr_busy   (wr_busy),
        .dipsw     (dipsw),
        .gpio_out  (gpio_out)
    );

    typedef struct {
        bit          wr;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    vec_t    vecs[$];
    rd_exp_t sb_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    bit      rd_issue = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Read results appear one edge after rd_addr is sampled; compare on the following negedge.
    initial begin : rd_monitor
        bit      cap;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            cap = rd_issue;
            @(negedge clk);
            if (cap) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: read data %08h with no expectation", rd_data);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, rd_data, e.exp);
                end
            end
        end
    end

    task automatic issue_read(input logic [13:0] a, input logic [31:0] e, input string n);
        rd_exp_t r;
        r.exp = e;
        r.name = n;
        rd_addr  = a;
        rd_issue = 1'b1;
        sb_q.push_back(r);
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] e, input string n);
        issue_read(a, e, n);
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_addr = a;
        wr_be   = {4'h0, be};
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_rd(input logic [13:0] a, input logic [31:0] e, input string n);
        vecs.push_back('{1'b0, a, 4'h0, 32'h0, e, n});
    endtask

    task automatic add_wr(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
        vecs.push_back('{1'b1, a, be, d, 32'h0, "wr"});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        add_rd(14'h1000, 32'h67452301, "id_reset");
        add_rd(14'h2000, 32'h00000000, "bar1_read_zero");
        add_rd(14'h3040, 32'h00000000, "bar3_read_zero");
        add_wr(14'h1000, 4'hF, 32'h11223344);
        add_rd(14'h1000, 32'h11223344, "id_full_write");
        add_wr(14'h1000, 4'h2, 32'h00AA0000);
        add_rd(14'h1000, 32'h11AA3344, "id_byte1_write");
        add_wr(14'h2000, 4'hF, 32'hFFFFFFFF);
        add_rd(14'h1040, 32'h11AA3344, "id_bar1_write_ignored");
        add_wr(14'h1009, 4'hF, 32'hDEADBEEF);
        add_rd(14'h1009, 32'hDEADBEEF, "scratch1");
        add_rd(14'h1008, 32'h00000000, "scratch0_clean");
        add_wr(14'h100B, 4'hF, 32'h0BADF00D);
        add_rd(14'h100B, 32'h0BADF00D, "scratch3_last");
        add_wr(14'h100C, 4'hF, 32'h77777777);
        add_rd(14'h100C, 32'h00000000, "offset_0c_unmapped");
        add_wr(14'h1001, 4'hF, 32'h12345678);
        add_rd(14'h1001, 32'h12000000, "gpio_upper_bits_zero");
        add_rd(14'h1002, 32'h00000000, "dipsw_idle");
        add_wr(14'h1002, 4'hF, 32'hFFFFFFFF);
        add_rd(14'h1002, 32'h00000000, "dipsw_read_only");
        add_rd(14'h1003, 32'h00000000, "status_idle");
`ifndef PIO_EP_TIMER_EN
        add_rd(14'h1004, 32'h00000000, "timer_lo_absent");
        add_rd(14'h1005, 32'h00000000, "timer_hi_absent");
`endif

        sys_rst_n = 1'b0;
        rd_addr   = '0;
        rd_be     = 4'hF;
        wr_addr   = '0;
        wr_be     = '0;
        wr_data   = '0;
        wr_en     = 1'b0;
        dipsw     = '0;
        idle(3);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
        check("rst_wr_busy", {31'h0, wr_busy}, 32'h0);
        sys_rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].be, vecs[i].data);
            else            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
            idle(1);
        end

        // GPIO commit lands on the second edge after wr_en
        wr_addr = 14'h1001; wr_be = 8'h01; wr_data = 32'hA5000000; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        check("gpio_not_yet_committed", {24'h0, gpio_out}, 32'h00000012);
        @(negedge clk);
        check("gpio_committed", {24'h0, gpio_out}, 32'h000000A5);
        rd(14'h1001, 32'hA5000000, "gpio_readback");
        idle(1);

        // FIFO overflow with commits stalled
        force dut.w_pop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check((k == 4) ? "busy_at_full" : "busy_below_full",
                  {31'h0, wr_busy}, (k == 4) ? 32'h1 : 32'h0);
            wr(14'h1008, 4'hF, 32'(k + 1));
        end
        check("busy_hold", {31'h0, wr_busy}, 32'h1);
        rd(14'h1003, 32'h04000080, "status_full_overflow");
        release dut.w_pop;
        idle(6);
        check("busy_cleared", {31'h0, wr_busy}, 32'h0);
        rd(14'h1008, 32'h00000004, "scratch0_fifth_dropped");
        rd(14'h1003, 32'h00000080, "status_overflow_sticky");
        wr(14'h1003, 4'h8, 32'h00000080);
        idle(1);
        rd(14'h1003, 32'h00000000, "status_w1c");

        // DIP switch debounce
        for (int k = 0; k < 10; k++) begin
            dipsw = k[0] ? 4'h0 : 4'h5;
            @(negedge clk);
        end
        dipsw = 4'h5;
        rd(14'h1002, 32'h00000000, "dipsw_while_bouncing");
        idle(11);
        rd(14'h1002, 32'h00000000, "dipsw_not_yet_stable");
        idle(12);
        rd(14'h1002, 32'h05000000, "dipsw_debounced");

`ifdef PIO_EP_TIMER_EN
        force dut.r_timer = 64'h00000000_FFFFFFFF;
        issue_read(14'h1004, 32'hFFFFFFFF, "timer_lo");
        @(negedge clk);
        release dut.r_timer;
        issue_read(14'h1005, 32'h00000000, "timer_hi_snapshot");
        @(negedge clk);
        rd_issue = 1'b0;
        idle(1);
`endif

        // Reset with writes still pending in the FIFO
        force dut.w_pop = 1'b0;
        wr(14'h1000, 4'hF, 32'hCAFEF00D);
        wr(14'h1009, 4'hF, 32'h00000000);
        wr(14'h1001, 4'hF, 32'hFFFFFFFF);
        rd(14'h1003, 32'h03000000, "status_level3_pending");
        sys_rst_n = 1'b0;
        #2;
        release dut.w_pop;
        idle(2);
        sys_rst_n = 1'b1;
        idle(3);
        rd(14'h1000, 32'h67452301, "id_after_reset");
        rd(14'h1003, 32'h00000000, "status_after_reset");
        check("gpio_after_reset", {24'h0, gpio_out}, 32'h0);

        idle(3);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
